// File: rtl/inst_sram_responder.sv
// inst_sram_responder: instruction SRAM port responder with registered word reads and byte-enabled writes.
// Programmable read wait states (WAIT_CYCLES, busy flag) exist only when INST_SRAM_WAIT_EN is defined.
module inst_sram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hbfc00000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_busy,
  output logic        inst_sram_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [32:0] LIMIT = 33'd4 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  idle;
  logic                  accept;
  logic                  rd_req;
  logic                  wr_req;
  logic                  rd_update;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_range;

  // 33-bit compare so the capacity bound cannot wrap for large ADDR_WIDTH
  assign offset   = inst_sram_addr - BASE_ADDR;
  assign in_range = {1'b0, offset} < LIMIT;
  assign idx      = offset[ADDR_WIDTH+1:2];

  assign accept = resetn && inst_sram_en && idle;
  assign rd_req = accept && (inst_sram_wen == 4'h0);
  assign wr_req = accept && (inst_sram_wen != 4'h0) && in_range;

`ifdef INST_SRAM_WAIT_EN
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic                  lat_range;
  logic                  lat_load;

  assign idle           = (state == S_IDLE);
  assign inst_sram_busy = (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_range <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (lat_load) begin
        lat_idx   <= idx;
        lat_range <= in_range;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lat_load   = 1'b0;
    rd_update  = 1'b0;
    rd_idx     = idx;
    rd_range   = in_range;
    case (state)
      S_IDLE: begin
        if (rd_req) begin
          if (WAIT_CNT == 4'd0) begin
            rd_update = 1'b1;
          end else begin
            lat_load   = 1'b1;
            cnt_next   = WAIT_CNT;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Result comes from the latched request; the live port is ignored here
        cnt_next = cnt - 4'd1;
        rd_idx   = lat_idx;
        rd_range = lat_range;
        if (cnt == 4'd1) begin
          rd_update  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end
`else
  assign idle           = 1'b1;
  assign inst_sram_busy = 1'b0;
  assign rd_update      = rd_req;
  assign rd_idx         = idx;
  assign rd_range       = in_range;
`endif

  always_ff @(posedge clk) begin
    if (wr_req) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (inst_sram_wen[i]) mem[idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_sram_rdata <= '0;
      inst_sram_err   <= 1'b0;
    end else if (rd_update) begin
      inst_sram_rdata <= rd_range ? mem[rd_idx] : '0;
      inst_sram_err   <= !rd_range;
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: cycle-numbered transaction model plus directed literal checks and random traffic.
module tb_inst_sram_responder;

  localparam int unsigned AW    = 10;
  localparam logic [31:0] BASE  = 32'hbfc00000;
  localparam int unsigned WC    = 3;
  localparam int unsigned WORDS = 1 << AW;
`ifdef INST_SRAM_WAIT_EN
  localparam int K = WC;
`else
  localparam int K = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  inst_sram_responder #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_sram_en   (en),
    .inst_sram_wen  (wen),
    .inst_sram_addr (addr),
    .inst_sram_wdata(wdata),
    .inst_sram_rdata(rdata),
    .inst_sram_busy (busy),
    .inst_sram_err  (err)
  );

  always #5 clk = ~clk;

  // Model: a read accepted at edge n publishes its result after edge n+K; port busy through edge n+K
  logic [31:0] shadow [WORDS];
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic        pend_err = 1'b0;
  int          cyc = 0;
  int          due = 0;
  int          busy_end = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          chk_on = 1'b0;

  task automatic model_edge();
    logic [31:0] off;
    logic        inr;
    int          wi;
    logic [31:0] d;
    cyc++;
    if (!resetn) begin
      m_rdata  = '0;
      m_err    = 1'b0;
      pend     = 1'b0;
      busy_end = cyc;
      return;
    end
    if (pend && cyc == due) begin
      m_rdata = pend_data;
      m_err   = pend_err;
      pend    = 1'b0;
    end else if (cyc > busy_end && en) begin
      off = addr - BASE;
      inr = off < 32'(4 * WORDS);
      wi  = int'(off >> 2);
      if (wen != 4'h0) begin
        if (inr) begin
          for (int b = 0; b < 4; b++)
            if (wen[b]) shadow[wi][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        d = '0;
        if (inr) d = shadow[wi];
        if (K == 0) begin
          m_rdata  = d;
          m_err    = !inr;
          busy_end = cyc;
        end else begin
          pend      = 1'b1;
          pend_data = d;
          pend_err  = !inr;
          due       = cyc + K;
          busy_end  = cyc + K;
        end
      end
    end
  endtask

  // Sets the inputs seen by the next rising edge and advances the model across that edge
  task automatic drive(input logic rn, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    resetn = rn;
    en     = e;
    wen    = w;
    addr   = a;
    wdata  = d;
    model_edge();
  endtask

  task automatic idle_cycle();
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 1'b1, 4'h0, a, 32'h0);
    repeat (K) idle_cycle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    drive(1'b1, 1'b1, w, a, d);
  endtask

  // Literal check on the outputs just after the edge set up by the last drive
  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      n_tests++;
      if (rdata !== m_rdata) begin
        n_fail++;
        $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, m_rdata);
      end
      n_tests++;
      if (err !== m_err) begin
        n_fail++;
        $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, m_err);
      end
      n_tests++;
      if (busy !== (cyc < busy_end)) begin
        n_fail++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc < busy_end));
      end
    end
  end

  initial begin
    logic        rn;
    logic        e;
    logic [3:0]  w;
    logic [31:0] a;
    int          sel;

    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk_on = 1'b1;
    drive(1'b0, 1'b1, 4'h0, BASE, 32'h0);
    sample();
    lit("reset_rdata", rdata, 32'h0);
    lit("reset_busy", {31'h0, busy}, 32'h0);
    lit("reset_err", {31'h0, err}, 32'h0);

    for (int i = 0; i < int'(WORDS); i++)
      wr(BASE + 32'(4 * i), 4'hf, (i == 0) ? 32'h24080001 : (32'(i) * 32'h9e3779b9) ^ 32'h5a5a0000);

    rd(BASE);
    sample();
    lit("preload_read", rdata, 32'h24080001);
    lit("preload_err", {31'h0, err}, 32'h0);
    lit("preload_busy", {31'h0, busy}, 32'h0);

    wr(BASE + 32'd20, 4'hf, 32'h11223344);
    wr(BASE + 32'd20, 4'b0101, 32'haabbccdd);
    rd(BASE + 32'd21);
    sample();
    lit("byte_enable", rdata, 32'h11bb33dd);

    rd(BASE + 32'h1000);
    sample();
    lit("oor_rdata", rdata, 32'h0);
    lit("oor_err", {31'h0, err}, 32'h1);
    rd(BASE + 32'h4);
    sample();
    lit("oor_clear_err", {31'h0, err}, 32'h0);
    wr(BASE + 32'h1000, 4'hf, 32'hdeadbeef);
    rd(BASE);
    sample();
    lit("oor_no_alias", rdata, 32'h24080001);

    // Read followed immediately by a conflicting request, then a reset shortly after
    drive(1'b1, 1'b1, 4'h0, BASE + 32'h8, 32'h0);
    drive(1'b1, 1'b1, 4'h0, BASE + 32'h1000, 32'h0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    lit("midwait_reset_rdata", rdata, 32'h0);
    lit("midwait_reset_busy", {31'h0, busy}, 32'h0);
    repeat (6) idle_cycle();
    sample();
    lit("midwait_no_late_update", rdata, 32'h0);

    drive(1'b1, 1'b1, 4'h0, BASE, 32'h0);
    drive(1'b1, 1'b1, 4'h0, BASE + 32'h4, 32'h0);
    repeat (2 * K + 2) idle_cycle();

    for (int n = 0; n < 3000; n++) begin
      rn  = ($urandom_range(0, 99) != 0);
      e   = ($urandom_range(0, 9) < 7);
      w   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       a = $urandom;
        1:       a = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 15));
        2:       a = BASE - 32'd1 - 32'($urandom_range(0, 7));
        3:       a = BASE + 32'(4 * WORDS) - 32'd4 + 32'($urandom_range(0, 3));
        default: a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      endcase
      drive(rn, e, w, a, $urandom);
    end
    repeat (K + 2) idle_cycle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
